aemb_intc: RTL

Interrupt controller for the AEMB core, upstream of the core's `sys_int_i` input. It collects up to `NIRQ` peripheral interrupt lines, synchronises them and latches edge events. It masks and aggregates them into a single registered interrupt request. Software services it as a WISHBONE slave on the data bus (`dwb`).

---
 rtl/aemb_intc_pkg.sv | 20 ++
 rtl/aemb_intc_if.sv | 31 +++
 rtl/aemb_intc_prienc.sv | 26 ++
 rtl/aemb_intc.sv | 118 +++++++++++
 4 files changed

// File: rtl/aemb_intc_pkg.sv
// ----------------------------------------------------------------------------
// aemb_intc_pkg
// Shared definitions for the AEMB interrupt controller: register offsets
// decoded from dwb_adr_i[3:2], the IVR valid-bit position and the largest
// supported number of interrupt sources.
// ----------------------------------------------------------------------------
package aemb_intc_pkg;

    // Register offsets (word index within the block).
    typedef enum logic [1:0] {
        INTC_ISR = 2'd0,    // pending status, write-1-clear for edge bits
        INTC_IER = 2'd1,    // enable mask
        INTC_IMR = 2'd2,    // mode: 1 = rising edge, 0 = level high
        INTC_IVR = 2'd3     // vector, read-only
    } intc_reg_e;

    localparam int IVR_VALID_BIT = 31;
    localparam int NIRQ_MAX      = 31;

endpackage

// File: rtl/aemb_intc_if.sv
// ----------------------------------------------------------------------------
// aemb_intc_if
// WISHBONE data-bus bundle between the core (master) and the interrupt
// controller (slave). Signal names keep the slave-side suffixes.
//   dwb_adr_i  [DSIZ-1:0]  address, only [3:2] decoded by the slave
//   dwb_dat_i  [31:0]      write data
//   dwb_we_i               write enable
//   dwb_stb_i              strobe, already qualified by the address decoder
//   dwb_dat_o  [31:0]      read data
//   dwb_ack_o              acknowledge
// ----------------------------------------------------------------------------
interface aemb_intc_if #(
    parameter int DSIZ = 32
);
    logic [DSIZ-1:0] dwb_adr_i;
    logic [31:0]     dwb_dat_i;
    logic            dwb_we_i;
    logic            dwb_stb_i;
    logic [31:0]     dwb_dat_o;
    logic            dwb_ack_o;

    modport slave (
        input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_stb_i,
        output dwb_dat_o, dwb_ack_o
    );

    modport master (
        output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_stb_i,
        input  dwb_dat_o, dwb_ack_o
    );
endinterface

// File: rtl/aemb_intc_prienc.sv
// ----------------------------------------------------------------------------
// aemb_intc_prienc
// Lowest-index priority encoder.
//   i_req   [N-1:0]  request vector
//   o_valid          any request set
//   o_idx   [4:0]    index of the lowest set bit, 0 when nothing is set
// ----------------------------------------------------------------------------
module aemb_intc_prienc #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [4:0]   o_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 5'(i);
        end
    end

endmodule

// File: rtl/aemb_intc.sv
// ----------------------------------------------------------------------------
// aemb_intc
// Interrupt controller feeding the AEMB core's sys_int_i. Each source is
// synchronised, optionally edge-latched, masked and OR-reduced into a
// registered request. Software accesses ISR/IER/IMR/IVR over WISHBONE.
//   sys_clk_i          clock, rising edge
//   sys_rst_i          asynchronous active-high reset
//   irq_i  [NIRQ-1:0]  raw interrupt sources, asynchronous
//   dwb                WISHBONE slave port (aemb_intc_if.slave)
//   sys_int_o          registered interrupt request
// Optional feature: define AEMB_INTC_VECTOR_EN to build the vector encoder;
// otherwise IVR reads 32'h0.
// ----------------------------------------------------------------------------
module aemb_intc
    import aemb_intc_pkg::*;
#(
    parameter int NIRQ = 8,
    parameter int DSIZ = 32     // width carried by the dwb interface instance
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [NIRQ-1:0] irq_i,
    aemb_intc_if.slave      dwb,
    output logic            sys_int_o
);

    logic [NIRQ-1:0] r_sync1, r_sync2, r_sync3;
    logic [NIRQ-1:0] r_isr, r_ier, r_imr;
    logic            r_ack, r_int;
    logic [31:0]     r_dat;

    logic            w_acc, w_wr;
    intc_reg_e       w_reg;
    logic [NIRQ-1:0] w_wdat, w_imr_nxt, w_clr, w_rise, w_to_edge, w_isr_nxt, w_pend;
    logic [31:0]     w_ivr, w_rdat;

    // An access is taken on the edge where ack rises; a held strobe therefore
    // gets one ack every other cycle.
    assign w_acc  = dwb.dwb_stb_i & ~r_ack;
    assign w_wr   = w_acc & dwb.dwb_we_i;
    assign w_reg  = intc_reg_e'(dwb.dwb_adr_i[3:2]);
    assign w_wdat = dwb.dwb_dat_i[NIRQ-1:0];

    assign w_imr_nxt = (w_wr && w_reg == INTC_IMR) ? w_wdat : r_imr;
    assign w_clr     = (w_wr && w_reg == INTC_ISR) ? w_wdat : '0;
    assign w_rise    = r_sync2 & ~r_sync3;
    // Bits switching from level to edge restart from 0.
    assign w_to_edge = w_imr_nxt & ~r_imr;
    // Edge bits: hold, clear on write-1, set wins over clear.
    // Level bits: follow the synchronised input, writes ignored.
    assign w_isr_nxt = (w_imr_nxt & ((r_isr & ~w_clr & ~w_to_edge) | w_rise))
                     | (~w_imr_nxt & r_sync2);
    assign w_pend    = r_isr & r_ier;

`ifdef AEMB_INTC_VECTOR_EN
    logic       w_vec_valid;
    logic [4:0] w_vec_idx;

    aemb_intc_prienc #(.N(NIRQ)) u_prienc (
        .i_req   (w_pend),
        .o_valid (w_vec_valid),
        .o_idx   (w_vec_idx)
    );

    always_comb begin
        w_ivr                = '0;
        w_ivr[IVR_VALID_BIT] = w_vec_valid;
        w_ivr[4:0]           = w_vec_idx;
    end
`else
    assign w_ivr = '0;
`endif

    always_comb begin
        w_rdat = '0;
        case (w_reg)
            INTC_ISR: w_rdat = 32'(r_isr);
            INTC_IER: w_rdat = 32'(r_ier);
            INTC_IMR: w_rdat = 32'(r_imr);
            INTC_IVR: w_rdat = w_ivr;
            default:  w_rdat = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_isr   <= '0;
            r_ier   <= '0;
            r_imr   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_int   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples pre-edge values (the synchroniser chain depends on it).
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_isr   <= w_isr_nxt;
            r_imr   <= w_imr_nxt;
            if (w_wr && w_reg == INTC_IER) r_ier <= w_wdat;
            r_ack   <= w_acc;
            r_dat   <= w_acc ? w_rdat : 32'h0;
            r_int   <= |w_pend;
        end
    end

    assign dwb.dwb_ack_o = r_ack;
    assign dwb.dwb_dat_o = r_dat;
    assign sys_int_o     = r_int;

    // Address bits outside [3:2] and data bits above NIRQ-1 are not decoded.
    logic w_unused;
    assign w_unused = ^{dwb.dwb_adr_i, dwb.dwb_dat_i};

endmodule
